// File: rtl/wb_burst_master_pkg.sv
// Shared types and Wishbone cycle-type constants for the burst master.
package wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUS  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_burst_master_if.sv
// Command, data and Wishbone signals between the burst master and its environment.
interface wb_burst_master_if #(
  parameter int unsigned APP_AW = 26,
  parameter int unsigned DW     = 32,
  parameter int unsigned LEN_W  = 8
) ();
  localparam int unsigned SW = DW / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [APP_AW-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wdat_valid;
  logic              wdat_ready;
  logic [DW-1:0]     wdat;
  logic              rdat_valid;
  logic [DW-1:0]     rdat;
  logic              busy;
  logic              done;
  logic              err;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [APP_AW-1:0] wb_addr_o;
  logic [SW-1:0]     wb_sel_o;
  logic [DW-1:0]     wb_dat_o;
  logic [DW-1:0]     wb_dat_i;
  logic [2:0]        wb_cti_o;
  logic              wb_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len, wdat_valid, wdat, wb_dat_i, wb_ack_i,
    output cmd_ready, wdat_ready, rdat_valid, rdat, busy, done, err,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_dat_o, wb_cti_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_len, wdat_valid, wdat, wb_dat_i, wb_ack_i,
    input  cmd_ready, wdat_ready, rdat_valid, rdat, busy, done, err,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_dat_o, wb_cti_o
  );
endinterface

// File: rtl/wb_burst_master_to_counter.sv
// Ack-timeout counter: expired fires on the cycle the count would reach TO_CYC.
module wb_to_counter #(
  parameter int unsigned TO_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int unsigned CW = $clog2(TO_CYC + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (clr)    count <= '0;
    else if (inc)    count <= count + CW'(1);
  end

  assign expired = inc && !clr && (count == CW'(TO_CYC - 1));
endmodule

// File: rtl/wb_burst_master.sv
// Wishbone incrementing-burst master with write-data flow control and ack timeout.
module wb_burst_master
  import wb_master_pkg::*;
#(
  parameter int unsigned APP_AW = 26,
  parameter int unsigned DW     = 32,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned TO_CYC = 255
) (
  input  logic              wb_clk_i,
  input  logic              resetn,
  wb_burst_master_if.master bus
);
  localparam int unsigned     SW        = DW / 8;
  localparam logic [APP_AW-1:0] ADDR_STEP = APP_AW'(SW);

  state_t            state, state_nxt;
  logic              we_q, single_q, mid_q;
  logic [APP_AW-1:0] addr_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [DW-1:0]     dat_q, rdat_q;
  logic              rdat_valid_q, err_q;
  logic              ack, last, stb, wdat_ready_c;
  logic              to_clr, to_inc, to_expired;

  assign stb  = (state == BUS);
  assign ack  = stb && bus.wb_ack_i;
  assign last = (cnt_q == '0);

  always_ff @(posedge wb_clk_i or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    wdat_ready_c = 1'b0;
    case (state)
      IDLE: if (bus.cmd_valid) state_nxt = bus.cmd_we ? LOAD : BUS;
      LOAD: begin
        wdat_ready_c = 1'b1;
        if (bus.wdat_valid) state_nxt = BUS;
      end
      BUS: begin
        if (ack) begin
          if (last) state_nxt = FIN;
          else if (we_q) begin
            wdat_ready_c = 1'b1;
            if (!bus.wdat_valid) state_nxt = LOAD;
          end
        end else if (to_expired) begin
          state_nxt = IDLE;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge resetn) begin
    if (!resetn) begin
      we_q         <= 1'b0;
      single_q     <= 1'b0;
      mid_q        <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      dat_q        <= '0;
      rdat_q       <= '0;
      rdat_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rdat_valid_q <= 1'b0;
      err_q        <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          we_q     <= bus.cmd_we;
          addr_q   <= bus.cmd_addr;
          cnt_q    <= bus.cmd_len;
          single_q <= (bus.cmd_len == '0);
          mid_q    <= 1'b0;
        end
        LOAD: if (bus.wdat_valid) dat_q <= bus.wdat;
        BUS: begin
          if (ack) begin
            if (!we_q) begin
              rdat_q       <= bus.wb_dat_i;
              rdat_valid_q <= 1'b1;
            end
            if (!last) begin
              addr_q <= addr_q + ADDR_STEP;
              cnt_q  <= cnt_q - LEN_W'(1);
              mid_q  <= 1'b1;
              if (we_q && bus.wdat_valid) dat_q <= bus.wdat;
            end
          end else if (to_expired) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Cleared on every ack and whenever BUS is freshly entered from LOAD/IDLE.
  assign to_clr = ((state != BUS) && (state_nxt == BUS)) || ack;
  assign to_inc = stb && !bus.wb_ack_i;

  wb_to_counter #(.TO_CYC(TO_CYC)) u_to (
    .clk     (wb_clk_i),
    .rst_n   (resetn),
    .clr     (to_clr),
    .inc     (to_inc),
    .expired (to_expired)
  );

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == FIN);
  assign bus.err        = err_q;
  assign bus.wdat_ready = wdat_ready_c;
  assign bus.rdat_valid = rdat_valid_q;
  assign bus.rdat       = rdat_q;
  assign bus.wb_stb_o   = stb;
  assign bus.wb_cyc_o   = stb || ((state == LOAD) && mid_q);
  assign bus.wb_we_o    = we_q;
  assign bus.wb_addr_o  = addr_q;
  assign bus.wb_sel_o   = {SW{stb}};
  assign bus.wb_dat_o   = dat_q;
  assign bus.wb_cti_o   = (!stb || single_q) ? CTI_CLASSIC : (last ? CTI_EOB : CTI_INCR);
endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master: burst table with beat scoreboard plus timeout and reset sequences.
module tb_wb_burst_master;
  import wb_master_pkg::*;

  localparam int unsigned APP_AW = 26;
  localparam int unsigned DW     = 32;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned TO_CYC = 255;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  wb_burst_master_if #(.APP_AW(APP_AW), .DW(DW), .LEN_W(LEN_W)) bus ();

  wb_burst_master #(.APP_AW(APP_AW), .DW(DW), .LEN_W(LEN_W), .TO_CYC(TO_CYC)) dut (
    .wb_clk_i (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  // Slave: acks whenever enabled (also while stb is low); read data encodes beat offset.
  logic              ack_en;
  logic [APP_AW-1:0] rd_base, rd_off;
  assign rd_off       = bus.wb_addr_o - rd_base;
  assign bus.wb_ack_i = ack_en;
  assign bus.wb_dat_i = {16'hA5A5, 16'(rd_off[APP_AW-1:2] + 1)};

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired, expected event did not occur", name);
  endtask

  typedef struct packed {
    logic [APP_AW-1:0] addr;
    logic [2:0]        cti;
    logic              we;
    logic              last;
    logic [DW-1:0]     dat;
  } beat_t;

  beat_t         beat_q[$];
  logic [DW-1:0] rdat_q[$];

  int unsigned       beats_seen = 0, gap_clks = 0, stb_clks = 0, done_cnt = 0, err_cnt = 0;
  logic [APP_AW-1:0] last_addr = '0;
  logic              prev_rd_ack = 1'b0, prev_last_ack = 1'b0;

  // Monitor: compares each acked beat and each read word against the scoreboard.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        beat_q.delete();
        rdat_q.delete();
        prev_rd_ack   = 1'b0;
        prev_last_ack = 1'b0;
      end else begin
        if (bus.rdat_valid || prev_rd_ack) begin
          check("rdat_valid_latency", bus.rdat_valid, prev_rd_ack);
          if (bus.rdat_valid) begin
            if (rdat_q.size() == 0) fail_now("rdat_unexpected");
            else check("rdat", bus.rdat, rdat_q.pop_front());
          end
        end
        if (bus.done || prev_last_ack) check("done_timing", bus.done, prev_last_ack);
        if (bus.done) check("cmd_ready_in_fin", bus.cmd_ready, 1'b0);
        if (bus.wb_stb_o) stb_clks++;
        if (bus.wb_cyc_o && !bus.wb_stb_o) gap_clks++;
        if (bus.done) done_cnt++;
        if (bus.err) err_cnt++;
        prev_rd_ack   = 1'b0;
        prev_last_ack = 1'b0;
        if (bus.wb_stb_o && bus.wb_ack_i) begin
          beats_seen++;
          last_addr = bus.wb_addr_o;
          if (beat_q.size() == 0) fail_now("beat_unexpected");
          else begin
            e = beat_q.pop_front();
            check("beat_addr", bus.wb_addr_o, e.addr);
            check("beat_cti", bus.wb_cti_o, e.cti);
            check("beat_we", bus.wb_we_o, e.we);
            check("beat_sel", bus.wb_sel_o, 4'hF);
            check("beat_cyc", bus.wb_cyc_o, 1'b1);
            if (e.we) check("beat_wdat", bus.wb_dat_o, e.dat);
            prev_rd_ack   = !e.we;
            prev_last_ack = e.last;
          end
        end
      end
    end
  end

  typedef struct {
    logic              we;
    logic [APP_AW-1:0] addr;
    logic [LEN_W-1:0]  len;
    int unsigned       gap;
    logic [APP_AW-1:0] exp_last;
    int unsigned       exp_beats;
    int unsigned       exp_gap;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [DW-1:0] wdata(input int unsigned k, input int unsigned i);
    return 32'hD000_0000 | DW'(k << 8) | DW'(i);
  endfunction

  task automatic issue_cmd(input logic we, input logic [APP_AW-1:0] addr, input logic [LEN_W-1:0] len);
    bit hs = 1'b0;
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_valid = 1'b1;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge clk);
      if (bus.cmd_ready) hs = 1'b1;
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    if (!hs) fail_now("cmd_handshake");
  endtask

  task automatic feed_wdat(input vec_t v, input int unsigned k);
    bit hs;
    for (int unsigned i = 0; i <= 32'(v.len); i++) begin
      bus.wdat       = wdata(k, i);
      bus.wdat_valid = 1'b1;
      hs = 1'b0;
      for (int c = 0; c < 50 && !hs; c++) begin
        @(negedge clk);
        if (bus.wdat_ready) hs = 1'b1;
      end
      @(posedge clk);
      #1 bus.wdat_valid = 1'b0;
      if (!hs) begin
        fail_now("wdat_handshake");
        return;
      end
      if (i < 32'(v.len) && v.gap > 0) begin
        repeat (v.gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_end(output bit got_done, output bit got_err);
    got_done = 1'b0;
    got_err  = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (bus.done) begin got_done = 1'b1; break; end
      if (bus.err)  begin got_err  = 1'b1; break; end
    end
    if (!got_done && !got_err) fail_now("burst_end");
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int unsigned k);
    int unsigned b0, g0, d0, e0;
    bit gd, ge;
    beat_t b;
    b0 = beats_seen; g0 = gap_clks; d0 = done_cnt; e0 = err_cnt;
    rd_base = v.addr;
    for (int unsigned i = 0; i <= 32'(v.len); i++) begin
      b.addr = v.addr + APP_AW'(4 * i);
      b.cti  = (v.len == 0) ? CTI_CLASSIC : ((i == 32'(v.len)) ? CTI_EOB : CTI_INCR);
      b.we   = v.we;
      b.last = (i == 32'(v.len));
      b.dat  = wdata(k, i);
      beat_q.push_back(b);
      if (!v.we) rdat_q.push_back({16'hA5A5, 16'(i + 1)});
    end
    @(posedge clk);
    #1;
    fork
      issue_cmd(v.we, v.addr, v.len);
      if (v.we) feed_wdat(v, k);
    join
    wait_end(gd, ge);
    check("vec_beats", beats_seen - b0, v.exp_beats);
    check("vec_last_addr", last_addr, v.exp_last);
    check("vec_gap_clks", gap_clks - g0, v.exp_gap);
    check("vec_done_count", done_cnt - d0, 1);
    check("vec_err_count", err_cnt - e0, 0);
    check("vec_beats_left", beat_q.size(), 0);
    check("vec_rdat_left", rdat_q.size(), 0);
    check("vec_idle_ready", bus.cmd_ready, 1'b1);
  endtask

  initial begin
    int unsigned s0, d0, e0;
    bit gd, ge, found;
    bus.cmd_valid  = 1'b0;
    bus.cmd_we     = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_len    = '0;
    bus.wdat_valid = 1'b0;
    bus.wdat       = '0;
    ack_en         = 1'b1;
    rd_base        = '0;

    vecs[0] = '{1'b1, 26'h000_0100, 8'd3, 0, 26'h000_010C, 4, 0};
    vecs[1] = '{1'b0, 26'h000_0200, 8'd0, 0, 26'h000_0200, 1, 0};
    vecs[2] = '{1'b1, 26'h000_0300, 8'd1, 3, 26'h000_0304, 2, 3};
    vecs[3] = '{1'b0, 26'h3FF_FFFC, 8'd1, 0, 26'h000_0000, 2, 0};
    vecs[4] = '{1'b0, 26'h000_0040, 8'd5, 0, 26'h000_0054, 6, 0};
    vecs[5] = '{1'b1, 26'h000_1000, 8'd0, 2, 26'h000_1000, 1, 0};
    vecs[6] = '{1'b1, 26'h000_0800, 8'd2, 1, 26'h000_0808, 3, 2};

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_cyc", bus.wb_cyc_o, 1'b0);
    check("rst_stb", bus.wb_stb_o, 1'b0);
    check("rst_cti", bus.wb_cti_o, 3'b000);
    check("rst_sel", bus.wb_sel_o, 4'h0);
    check("rst_addr", bus.wb_addr_o, 26'h0);
    resetn = 1'b1;

    for (int unsigned k = 0; k < 7; k++) run_vec(vecs[k], k);

    // Slave silent: BUS must last TO_CYC clocks, then a single err and no done.
    ack_en = 1'b0;
    s0 = stb_clks; d0 = done_cnt; e0 = err_cnt;
    @(posedge clk);
    #1 issue_cmd(1'b0, 26'h000_0500, 8'd0);
    wait_end(gd, ge);
    check("to_err_seen", ge, 1'b1);
    check("to_stb_clks", stb_clks - s0, TO_CYC);
    check("to_err_count", err_cnt - e0, 1);
    check("to_done_count", done_cnt - d0, 0);
    check("to_cmd_ready", bus.cmd_ready, 1'b1);
    check("to_cyc", bus.wb_cyc_o, 1'b0);

    // Reset during beat 2 of a 4-beat read: cyc/stb must drop before any clock edge.
    ack_en = 1'b1;
    d0 = done_cnt; e0 = err_cnt;
    begin
      beat_t b;
      rd_base = 26'h000_0600;
      for (int unsigned i = 0; i < 4; i++) begin
        b.addr = 26'h000_0600 + APP_AW'(4 * i);
        b.cti  = (i == 3) ? CTI_EOB : CTI_INCR;
        b.we   = 1'b0;
        b.last = (i == 3);
        b.dat  = '0;
        beat_q.push_back(b);
        rdat_q.push_back({16'hA5A5, 16'(i + 1)});
      end
    end
    @(posedge clk);
    #1 issue_cmd(1'b0, 26'h000_0600, 8'd3);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bus.wb_stb_o && bus.wb_addr_o == 26'h000_0604) found = 1'b1;
    end
    if (!found) fail_now("rst_reach_beat2");
    #2 resetn = 1'b0;
    #1;
    check("rst_async_cyc", bus.wb_cyc_o, 1'b0);
    check("rst_async_stb", bus.wb_stb_o, 1'b0);
    check("rst_async_busy", bus.busy, 1'b0);
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    check("post_rst_ready", bus.cmd_ready, 1'b1);
    check("post_rst_cyc", bus.wb_cyc_o, 1'b0);
    check("post_rst_we", bus.wb_we_o, 1'b0);
    check("post_rst_addr", bus.wb_addr_o, 26'h0);
    check("post_rst_dat", bus.wb_dat_o, 32'h0);
    check("post_rst_rdat", bus.rdat, 32'h0);
    check("post_rst_rdat_valid", bus.rdat_valid, 1'b0);
    check("post_rst_cti", bus.wb_cti_o, 3'b000);
    check("post_rst_sel", bus.wb_sel_o, 4'h0);
    repeat (3) @(negedge clk);
    check("post_rst_done_count", done_cnt - d0, 0);
    check("post_rst_err_count", err_cnt - e0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end
endmodule
